window_sequencer: RTL

WINDOW_SEQUENCER -- requirements
Module: window_sequencer

---
 rtl/window_sequencer_pkg.sv | 12 +
 rtl/window_sequencer_line_buffer.sv | 24 ++
 rtl/window_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/window_sequencer_pkg.sv
// Shared types and constants for the 3x3 window sequencer.
package window_sequencer_pkg;

  typedef enum logic {
    ACCEPT = 1'b0,
    EMIT   = 1'b1
  } state_t;

  localparam logic [3:0] SEL_LAST = 4'd8;
  localparam logic [3:0] SEL_IDLE = 4'd15;

endpackage

// File: rtl/window_sequencer_line_buffer.sv
// One-row pixel store: combinational read of the old word, write on the clock edge.
module line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Storage write; contents are never reset because stale rows are never emitted.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/window_sequencer.sv
// Raster-order pixel stream in, 3x3 neighbourhood out as nine serial beats per window.
module window_sequencer
  import window_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pix_in,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  output logic [3:0]       demux_sel,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             window_last,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_win_q, last_win_d;
  logic [WIDTH-1:0] win_q [9];
  logic [WIDTH-1:0] win_d [9];
  logic [WIDTH-1:0] lb1_rd, lb2_rd;
  logic             accept;

  logic [3:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             fd_q, fd_d;

  assign accept       = pix_in_valid && (state_q == ACCEPT);
  assign pix_in_ready = (state_q == ACCEPT);
  assign demux_sel    = sel_q;
  assign data         = data_q;
  assign data_valid   = valid_q;
  assign window_last  = last_q;
  assign frame_done   = fd_q;

  // lb1 holds row r-1, lb2 holds row r-2; the old lb1 word cascades into lb2.
  line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb1 (
    .clk    (clk),
    .we_i   (accept),
    .addr_i (col_q),
    .wdata_i(pix_in),
    .rdata_o(lb1_rd)
  );

  line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb2 (
    .clk    (clk),
    .we_i   (accept),
    .addr_i (col_q),
    .wdata_i(lb1_rd),
    .rdata_o(lb2_rd)
  );

  // Next-state, counters, window shift and next output values.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    last_win_d = last_win_q;
    win_d      = win_q;
    sel_d      = SEL_IDLE;
    data_d     = {WIDTH{1'b0}};
    valid_d    = 1'b0;
    last_d     = 1'b0;
    fd_d       = 1'b0;

    case (state_q)
      ACCEPT: begin
        if (accept) begin
          win_d[0] = win_q[1];
          win_d[1] = win_q[2];
          win_d[2] = lb2_rd;
          win_d[3] = win_q[4];
          win_d[4] = win_q[5];
          win_d[5] = lb1_rd;
          win_d[6] = win_q[7];
          win_d[7] = win_q[8];
          win_d[8] = pix_in;
          if (col_q == CW'(IMG_W - 1)) begin
            col_d = {CW{1'b0}};
            if (row_q == RW'(IMG_H - 1)) begin
              row_d = {RW{1'b0}};
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
          // Columns 0 and 1 never trigger, so a window never straddles a row edge.
          if ((row_q >= RW'(2)) && (col_q >= CW'(2))) begin
            state_d    = EMIT;
            cnt_d      = 4'd0;
            last_win_d = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
          end else begin
            state_d = ACCEPT;
          end
        end else begin
          state_d = ACCEPT;
        end
      end
      EMIT: begin
        sel_d   = cnt_q;
        data_d  = win_q[cnt_q];
        valid_d = 1'b1;
        last_d  = (cnt_q == SEL_LAST);
        fd_d    = (cnt_q == SEL_LAST) && last_win_q;
        if (cnt_q == SEL_LAST) begin
          state_d = ACCEPT;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ACCEPT;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCEPT;
      col_q      <= {CW{1'b0}};
      row_q      <= {RW{1'b0}};
      cnt_q      <= 4'd0;
      last_win_q <= 1'b0;
      sel_q      <= SEL_IDLE;
      data_q     <= {WIDTH{1'b0}};
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      last_win_q <= last_win_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      fd_q       <= fd_d;
    end
  end

  // Window pixels; frozen whenever no pixel is accepted.
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

endmodule
